// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU sprite evaluation slice: FSM states,
// OAM byte layout and sprite heights.
package ppu_pkg;

    // Sprite evaluator states, one OAM entry is walked at a time
    typedef enum logic [3:0] {
        IDLE,
        Y_ADDR,
        Y_CHECK,
        T_ADDR,
        T_CAP,
        A_CAP,
        X_CAP,
        NEXT,
        COMMIT
    } eval_state_e;

    // Byte offsets inside one 4-byte OAM entry
    localparam logic [1:0] OAM_BYTE_Y    = 2'd0;
    localparam logic [1:0] OAM_BYTE_TILE = 2'd1;
    localparam logic [1:0] OAM_BYTE_ATTR = 2'd2;
    localparam logic [1:0] OAM_BYTE_X    = 2'd3;

    // Sprite heights, sized to compare against a 9-bit row offset
    localparam logic [8:0] SPRITE_H_8  = 9'd8;
    localparam logic [8:0] SPRITE_H_16 = 9'd16;

    // Byte address of byte b of OAM entry n
    function automatic logic [7:0] oamByteAddr(input logic [5:0] entry, input logic [1:0] b);
        return {entry, b};
    endfunction

endpackage

// File: rtl/sprite_tile_overlap.sv
// Flags whether a sprite starting at column col_i touches the 8-pixel tile
// starting at curr_col_i (two's complement, may be as low as -7).
module sprite_tile_overlap (
    input  logic [7:0] col_i,
    input  logic [8:0] curr_col_i,
    input  logic       valid_i,
    output logic       onTile_o
);

    logic signed [9:0] colDiff;

    // Distance between sprite and tile start; overlap when within one tile width
    always_comb begin
        colDiff  = $signed({2'b00, col_i}) - $signed({curr_col_i[8], curr_col_i});
        onTile_o = valid_i && (colDiff >= -10'sd7) && (colDiff <= 10'sd7);
    end

endmodule

// File: rtl/ppu_sprite_eval_fsm.sv
// Per-scanline sprite evaluator: walks OAM for the requested row, keeps the
// first two hits in working slots and publishes them at COMMIT so the
// downstream load FSM always sees a stable set while the next line is scanned.
module ppu_sprite_eval_fsm
    import ppu_pkg::*;
#(
    parameter int OAM_ENTRIES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] eval_row,
    input  logic [8:0] curr_col,
    input  logic [7:0] ppu_ctrl1,
    input  logic [7:0] ppu_ctrl2,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_data,
    output logic       busy,
    output logic       done,
    output logic       sprite_overflow,
    output logic       sprite_0_valid,
    output logic       sprite_1_valid,
    output logic [7:0] sprite_0_tile_num,
    output logic [7:0] sprite_0_row,
    output logic [7:0] sprite_0_col,
    output logic [7:0] sprite_0_attr,
    output logic [7:0] sprite_1_tile_num,
    output logic [7:0] sprite_1_row,
    output logic [7:0] sprite_1_col,
    output logic [7:0] sprite_1_attr,
    output logic       sprite_0_is_oam0,
    output logic       sprite_0_on_tile,
    output logic       sprite_1_on_tile
);

    localparam int IDX_W = $clog2(OAM_ENTRIES);

    eval_state_e state_q, state_d;

    logic [IDX_W-1:0] entry_q;
    logic [8:0]       evalRow_q;
    logic             tall_q;
    logic             slotSel_q;

    logic [1:0]       wValid_q;
    logic [1:0][7:0]  wTile_q, wRow_q, wCol_q, wAttr_q;
    logic             wIsOam0_q, wOvf_q;

    logic [1:0]       cValid_q;
    logic [1:0][7:0]  cTile_q, cRow_q, cCol_q, cAttr_q;
    logic             cIsOam0_q, cOvf_q;

    logic [9:0]       yDiff;
    logic             yInRange;
    logic             lastEntry;
    logic [5:0]       entryAddr;
    logic             unusedCtrlBits;

    assign unusedCtrlBits = ^{ppu_ctrl1[7:6], ppu_ctrl1[4:0], ppu_ctrl2[7:5], ppu_ctrl2[3:0]};

    assign entryAddr = 6'(entry_q);
    assign lastEntry = (entry_q == IDX_W'(OAM_ENTRIES - 1));

    // Row offset into the sprite; a negative result means the sprite starts below this row
    always_comb begin
        yDiff    = {1'b0, evalRow_q} - {2'b00, oam_data};
        yInRange = !yDiff[9] && (yDiff[8:0] < (tall_q ? SPRITE_H_16 : SPRITE_H_8));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: 3 cycles per miss, 7 per captured hit, early exit on overflow
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ppu_ctrl2[4] ? Y_ADDR : COMMIT;
            Y_ADDR:  state_d = Y_CHECK;
            Y_CHECK: begin
                if (!yInRange)               state_d = NEXT;
                else if (wValid_q != 2'b11)  state_d = T_ADDR;
                else                         state_d = COMMIT;
            end
            T_ADDR:  state_d = T_CAP;
            T_CAP:   state_d = A_CAP;
            A_CAP:   state_d = X_CAP;
            X_CAP:   state_d = NEXT;
            NEXT:    state_d = lastEntry ? COMMIT : Y_ADDR;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: OAM address runs one byte ahead of the capture state; done marks the commit cycle
    always_comb begin
        oam_addr = oamByteAddr(entryAddr, OAM_BYTE_Y);
        busy     = (state_q != IDLE) && (state_q != COMMIT);
        done     = (state_q == COMMIT);
        case (state_q)
            T_ADDR:  oam_addr = oamByteAddr(entryAddr, OAM_BYTE_TILE);
            T_CAP:   oam_addr = oamByteAddr(entryAddr, OAM_BYTE_ATTR);
            A_CAP:   oam_addr = oamByteAddr(entryAddr, OAM_BYTE_X);
            default: oam_addr = oamByteAddr(entryAddr, OAM_BYTE_Y);
        endcase
    end

    // Working slots: cleared on start, filled with the first two in-range entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q   <= '0;
            evalRow_q <= '0;
            tall_q    <= 1'b0;
            slotSel_q <= 1'b0;
            wValid_q  <= '0;
            wTile_q   <= '0;
            wRow_q    <= '0;
            wCol_q    <= '0;
            wAttr_q   <= '0;
            wIsOam0_q <= 1'b0;
            wOvf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        entry_q   <= '0;
                        evalRow_q <= eval_row;
                        tall_q    <= ppu_ctrl1[5];
                        slotSel_q <= 1'b0;
                        wValid_q  <= '0;
                        wTile_q   <= '0;
                        wRow_q    <= '0;
                        wCol_q    <= '0;
                        wAttr_q   <= '0;
                        wIsOam0_q <= 1'b0;
                        wOvf_q    <= 1'b0;
                    end
                end
                Y_CHECK: begin
                    if (yInRange) begin
                        if (!wValid_q[0]) begin
                            slotSel_q   <= 1'b0;
                            wValid_q[0] <= 1'b1;
                            wRow_q[0]   <= yDiff[7:0];
                            wIsOam0_q   <= (entry_q == '0);
                        end else if (!wValid_q[1]) begin
                            slotSel_q   <= 1'b1;
                            wValid_q[1] <= 1'b1;
                            wRow_q[1]   <= yDiff[7:0];
                        end else begin
                            wOvf_q      <= 1'b1;
                        end
                    end
                end
                T_CAP:   wTile_q[slotSel_q] <= oam_data;
                A_CAP:   wAttr_q[slotSel_q] <= oam_data;
                X_CAP:   wCol_q[slotSel_q]  <= oam_data;
                NEXT:    if (!lastEntry) entry_q <= entry_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Committed slots: only updated at COMMIT so the load FSM sees stable values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cValid_q  <= '0;
            cTile_q   <= '0;
            cRow_q    <= '0;
            cCol_q    <= '0;
            cAttr_q   <= '0;
            cIsOam0_q <= 1'b0;
            cOvf_q    <= 1'b0;
        end else if (state_q == COMMIT) begin
            cValid_q  <= wValid_q;
            cTile_q   <= wTile_q;
            cRow_q    <= wRow_q;
            cCol_q    <= wCol_q;
            cAttr_q   <= wAttr_q;
            cIsOam0_q <= wIsOam0_q;
            cOvf_q    <= wOvf_q;
        end
    end

    assign sprite_overflow   = cOvf_q;
    assign sprite_0_valid    = cValid_q[0];
    assign sprite_1_valid    = cValid_q[1];
    assign sprite_0_tile_num = cTile_q[0];
    assign sprite_0_row      = cRow_q[0];
    assign sprite_0_col      = cCol_q[0];
    assign sprite_0_attr     = cAttr_q[0];
    assign sprite_1_tile_num = cTile_q[1];
    assign sprite_1_row      = cRow_q[1];
    assign sprite_1_col      = cCol_q[1];
    assign sprite_1_attr     = cAttr_q[1];
    assign sprite_0_is_oam0  = cIsOam0_q;

    sprite_tile_overlap uOverlap0 (
        .col_i      (cCol_q[0]),
        .curr_col_i (curr_col),
        .valid_i    (cValid_q[0]),
        .onTile_o   (sprite_0_on_tile)
    );

    sprite_tile_overlap uOverlap1 (
        .col_i      (cCol_q[1]),
        .curr_col_i (curr_col),
        .valid_i    (cValid_q[1]),
        .onTile_o   (sprite_1_on_tile)
    );

endmodule

// File: tb/tb_ppu_sprite_eval_fsm.sv
// Directed self-checking bench for ppu_sprite_eval_fsm with a behavioural
// OAM and a scoreboard of expected committed results.
module tb_ppu_sprite_eval_fsm;

    typedef struct packed {
        logic       v0;
        logic       v1;
        logic       o0;
        logic       ovf;
        logic [7:0] t0, r0, c0, a0;
        logic [7:0] t1, r1, c1, a1;
        int         cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] eval_row;
    logic [8:0] curr_col;
    logic [7:0] ppu_ctrl1, ppu_ctrl2;
    logic [7:0] oam_addr;
    logic [7:0] oam_data = 8'h00;
    logic       busy, done, sprite_overflow;
    logic       sprite_0_valid, sprite_1_valid;
    logic [7:0] sprite_0_tile_num, sprite_0_row, sprite_0_col, sprite_0_attr;
    logic [7:0] sprite_1_tile_num, sprite_1_row, sprite_1_col, sprite_1_attr;
    logic       sprite_0_is_oam0, sprite_0_on_tile, sprite_1_on_tile;

    logic [7:0] oam [0:255];
    exp_t       sb[$];
    exp_t       lastCommitted = '0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Synchronous OAM: data valid one cycle after the address
    always @(posedge clk) oam_data <= oam[oam_addr];

    ppu_sprite_eval_fsm #(.OAM_ENTRIES(64)) dut (
        .clk(clk), .rst(rst), .start(start), .eval_row(eval_row), .curr_col(curr_col),
        .ppu_ctrl1(ppu_ctrl1), .ppu_ctrl2(ppu_ctrl2), .oam_addr(oam_addr), .oam_data(oam_data),
        .busy(busy), .done(done), .sprite_overflow(sprite_overflow),
        .sprite_0_valid(sprite_0_valid), .sprite_1_valid(sprite_1_valid),
        .sprite_0_tile_num(sprite_0_tile_num), .sprite_0_row(sprite_0_row),
        .sprite_0_col(sprite_0_col), .sprite_0_attr(sprite_0_attr),
        .sprite_1_tile_num(sprite_1_tile_num), .sprite_1_row(sprite_1_row),
        .sprite_1_col(sprite_1_col), .sprite_1_attr(sprite_1_attr),
        .sprite_0_is_oam0(sprite_0_is_oam0),
        .sprite_0_on_tile(sprite_0_on_tile), .sprite_1_on_tile(sprite_1_on_tile)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fillOam(input logic [7:0] yDefault);
        for (int i = 0; i < 64; i++) begin
            oam[i*4]   = yDefault;
            oam[i*4+1] = 8'(i);
            oam[i*4+2] = 8'h00;
            oam[i*4+3] = 8'(i*2);
        end
    endtask

    task automatic setEntry(input int n, input logic [7:0] y, input logic [7:0] t,
                            input logic [7:0] a, input logic [7:0] x);
        oam[n*4]   = y;
        oam[n*4+1] = t;
        oam[n*4+2] = a;
        oam[n*4+3] = x;
    endtask

    // Reference evaluation over the bench OAM, including expected cycle count
    function automatic exp_t modelEval(input int row, input bit tall, input bit en);
        exp_t e;
        int   h;
        int   d;
        int   cyc;
        e = '0;
        if (!en) return e;
        h   = tall ? 16 : 8;
        cyc = 0;
        for (int n = 0; n < 64; n++) begin
            d = row - int'(oam[n*4]);
            if (d >= 0 && d < h) begin
                if (!e.v0) begin
                    e.v0 = 1'b1; e.o0 = (n == 0); e.r0 = 8'(d);
                    e.t0 = oam[n*4+1]; e.a0 = oam[n*4+2]; e.c0 = oam[n*4+3];
                    cyc += 7;
                end else if (!e.v1) begin
                    e.v1 = 1'b1; e.r1 = 8'(d);
                    e.t1 = oam[n*4+1]; e.a1 = oam[n*4+2]; e.c1 = oam[n*4+3];
                    cyc += 7;
                end else begin
                    e.ovf = 1'b1;
                    cyc += 2;
                    break;
                end
            end else begin
                cyc += 3;
            end
        end
        e.cycles = cyc + 1;
        return e;
    endfunction

    task automatic checkCommitted(input exp_t e);
        checkOutput("s0_valid", sprite_0_valid, e.v0);
        checkOutput("s1_valid", sprite_1_valid, e.v1);
        checkOutput("overflow", sprite_overflow, e.ovf);
        checkOutput("s0_is_oam0", sprite_0_is_oam0, e.o0);
        checkOutput("s0_tile", sprite_0_tile_num, e.t0);
        checkOutput("s0_row", sprite_0_row, e.r0);
        checkOutput("s0_col", sprite_0_col, e.c0);
        checkOutput("s0_attr", sprite_0_attr, e.a0);
        checkOutput("s1_tile", sprite_1_tile_num, e.t1);
        checkOutput("s1_row", sprite_1_row, e.r1);
        checkOutput("s1_col", sprite_1_col, e.c1);
        checkOutput("s1_attr", sprite_1_attr, e.a1);
    endtask

    // One evaluation: push the model result, run the DUT, pop and compare at done
    task automatic applyStimulus(input int row, input logic [7:0] c1, input logic [7:0] c2,
                                 input bit extraStart);
        exp_t e;
        int   k;
        sb.push_back(modelEval(row, c1[5], c2[4]));
        @(negedge clk);
        eval_row  = 9'(row);
        ppu_ctrl1 = c1;
        ppu_ctrl2 = c2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 400) begin
            if (k == 5 && c2[4]) checkOutput("busy_mid", busy, 1);
            if (k == 10) checkOutput("committed_stable", sprite_0_tile_num, lastCommitted.t0);
            @(negedge clk);
            k++;
            start = (extraStart && k == 20);
            if (extraStart && k == 20) eval_row = 9'd0;
        end
        start = 1'b0;
        e = sb.pop_front();
        checkOutput("done_seen", done, 1);
        checkOutput("busy_at_done", busy, 0);
        if (e.cycles != 0) checkOutput("latency", k, e.cycles);
        else               checkOutput("disabled_latency", k <= 2, 1);
        @(negedge clk);
        checkOutput("done_pulse", done, 0);
        checkCommitted(e);
        lastCommitted = e;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; eval_row = '0; curr_col = '0;
        ppu_ctrl1 = 8'h00; ppu_ctrl2 = 8'h00;
        fillOam(8'hF0);
        repeat (2) @(negedge clk);
        checkOutput("rst_oam_addr", oam_addr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkCommitted('0);
        rst = 1'b0;

        $display("[TB] sprites disabled");
        applyStimulus(15, 8'h00, 8'h00, 1'b0);

        $display("[TB] two sprites on row 15, stray start mid-evaluation");
        setEntry(0, 8'd10, 8'h21, 8'h41, 8'd100);
        setEntry(5, 8'd12, 8'h22, 8'h03, 8'd180);
        applyStimulus(15, 8'h00, 8'h10, 1'b1);
        @(negedge clk); curr_col = 9'd100; #1;
        checkOutput("on_tile_s0_hit", sprite_0_on_tile, 1);
        checkOutput("on_tile_s1_far", sprite_1_on_tile, 0);
        @(negedge clk); curr_col = 9'd175; #1;
        checkOutput("on_tile_s0_far", sprite_0_on_tile, 0);
        checkOutput("on_tile_s1_hit", sprite_1_on_tile, 1);

        $display("[TB] overflow with three sprites on row 20");
        fillOam(8'hF0);
        setEntry(3, 8'd20, 8'h13, 8'h01, 8'd30);
        setEntry(7, 8'd20, 8'h17, 8'h02, 8'd70);
        setEntry(9, 8'd20, 8'h19, 8'h03, 8'd90);
        applyStimulus(20, 8'h00, 8'h10, 1'b0);

        $display("[TB] reset in the middle of an evaluation");
        fillOam(8'hF0);
        setEntry(0, 8'd10, 8'h21, 8'h41, 8'd100);
        setEntry(5, 8'd12, 8'h22, 8'h03, 8'd180);
        @(negedge clk);
        eval_row = 9'd15; ppu_ctrl1 = 8'h00; ppu_ctrl2 = 8'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        checkOutput("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_oam_addr", oam_addr, 0);
        checkCommitted('0);
        lastCommitted = '0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(15, 8'h00, 8'h10, 1'b0);

        $display("[TB] 8x16 and 8x8 height boundaries");
        fillOam(8'hF0);
        setEntry(2, 8'd50, 8'h33, 8'h02, 8'd3);
        applyStimulus(65, 8'h20, 8'h10, 1'b0);
        @(negedge clk); curr_col = 9'h1FC; #1;
        checkOutput("on_tile_m4", sprite_0_on_tile, 1);
        @(negedge clk); curr_col = 9'd11; #1;
        checkOutput("on_tile_11", sprite_0_on_tile, 0);
        @(negedge clk); curr_col = 9'd10; #1;
        checkOutput("on_tile_10", sprite_0_on_tile, 1);
        checkOutput("on_tile_s1_invalid", sprite_1_on_tile, 0);
        applyStimulus(66, 8'h20, 8'h10, 1'b0);
        applyStimulus(57, 8'h00, 8'h10, 1'b0);
        applyStimulus(58, 8'h00, 8'h10, 1'b0);

        $display("[TB] Y=255 on row 0 does not wrap");
        setEntry(2, 8'd255, 8'h44, 8'h00, 8'd8);
        applyStimulus(0, 8'h00, 8'h10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
